// File: rtl/vga_pkg.sv
// Default VGA timing, RD_LAT bound, width helper and the sideband record
// that travels down the output delay line.
package vga_pkg;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int RD_LAT_MAX = 3;

  // Never returns less than 1 so that degenerate sizes still give a legal vector.
  function automatic int vga_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
    logic vb;
  } vga_sb_t;
endpackage

// File: rtl/vga_sync_counter.sv
// One raster axis: sync, back porch, active, front porch counter advancing on tick.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int SYNC   = H_SYNC_D,
  parameter int BP     = H_BP_D,
  parameter int ACTIVE = H_ACTIVE_D,
  parameter int FP     = H_FP_D,
  localparam int TOTAL = SYNC + BP + ACTIVE + FP,
  localparam int CW    = vga_clog2(TOTAL + 1),
  localparam int VW    = vga_clog2(ACTIVE)
) (
  input  logic          vga_clk,
  input  logic          clr,
  input  logic          en,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          active,
  output logic [VW-1:0] vis
);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] S_HI = CW'(SYNC);
  localparam logic [CW-1:0] A_LO = CW'(SYNC + BP);
  localparam logic [CW-1:0] A_HI = CW'(SYNC + BP + ACTIVE);

  logic [CW-1:0] cnt_q, cnt_d, vis_full;

  always_comb begin
    cnt_d = cnt_q;
    if (!en)       cnt_d = '0;
    else if (tick) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge vga_clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count    = cnt_q;
  assign wrap     = en & tick & (cnt_q == LAST);
  assign sync     = cnt_q < S_HI;
  assign active   = (cnt_q >= A_LO) && (cnt_q < A_HI);
  assign vis_full = cnt_q - A_LO;
  assign vis      = active ? vis_full[VW-1:0] : '0;
endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster controller: h/v counters, registered RAM address stage, RD_LAT
// sideband delay line and colour register so sync/de/strobes line up with r/g/b.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 8,
  parameter int   RD_LAT   = 0,
  localparam int  ROW_W    = vga_clog2(V_ACTIVE),
  localparam int  COL_W    = vga_clog2(H_ACTIVE)
) (
  input  logic                 vga_clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 scale2x,
  input  logic [3*COLOR_W-1:0] d_in,
  output logic [ROW_W-1:0]     row_addr,
  output logic [COL_W-1:0]     col_addr,
  output logic                 rdn,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 hs,
  output logic                 vs,
  output logic                 de,
  output logic                 frame_start,
  output logic                 line_start,
  output logic                 vblank
);
  localparam int HCW = vga_clog2(H_SYNC + H_BP + H_ACTIVE + H_FP + 1);
  localparam int VCW = vga_clog2(V_SYNC + V_BP + V_ACTIVE + V_FP + 1);
  localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 0) ? 0 : RD_LAT);
  localparam vga_sb_t SB_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0,
                                  fs: 1'b0, ls: 1'b0, vb: 1'b1};

  logic [HCW-1:0]   h_cnt;
  logic [VCW-1:0]   v_cnt;
  logic [COL_W-1:0] h_vis;
  logic [ROW_W-1:0] v_vis;
  logic             h_wrap, h_sync, h_act, v_wrap, v_sync, v_act;
  logic             unused_v_wrap;

  vga_sync_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)) u_h (
    .vga_clk(vga_clk), .clr(clr), .en(en), .tick(1'b1),
    .count(h_cnt), .wrap(h_wrap), .sync(h_sync), .active(h_act), .vis(h_vis)
  );

  vga_sync_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)) u_v (
    .vga_clk(vga_clk), .clr(clr), .en(en), .tick(h_wrap),
    .count(v_cnt), .wrap(v_wrap), .sync(v_sync), .active(v_act), .vis(v_vis)
  );

  assign unused_v_wrap = v_wrap;

  // Stage 0 is idle whenever en is low, so a disabled raster emits no syncs or strobes.
  logic    first_px;
  vga_sb_t sb0;
  assign first_px = (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    sb0 = SB_IDLE;
    if (en) begin
      sb0.hs = h_sync ? HS_POL : ~HS_POL;
      sb0.vs = v_sync ? VS_POL : ~VS_POL;
      sb0.de = h_act & v_act;
      sb0.fs = first_px;
      sb0.ls = (h_cnt == '0);
      sb0.vb = ~v_act;
    end
  end

  logic             scale_q, rdn_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = '0;
    row_d = '0;
    if (sb0.de) begin
      col_d = scale_q ? (h_vis >> 1) : h_vis;
      row_d = scale_q ? (v_vis >> 1) : v_vis;
    end
  end

  // scale_q only moves at the top-left corner, so a frame never mixes modes.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      scale_q <= 1'b0;
      rdn_q   <= 1'b1;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      if (en && first_px) scale_q <= scale2x;
      rdn_q <= ~sb0.de;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  vga_sb_t              sb_pipe_q [LAT:0];
  vga_sb_t              out_q;
  logic [3*COLOR_W-1:0] rgb_q;

  always_ff @(posedge vga_clk) begin
    if (clr) begin
      for (int i = 0; i <= LAT; i++) sb_pipe_q[i] <= SB_IDLE;
    end else begin
      sb_pipe_q[0] <= sb0;
      for (int i = 1; i <= LAT; i++) sb_pipe_q[i] <= sb_pipe_q[i-1];
    end
  end

  // sb_pipe_q[LAT] is in the cycle where d_in holds the pixel for the same position.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      out_q <= SB_IDLE;
      rgb_q <= '0;
    end else begin
      out_q <= sb_pipe_q[LAT];
      rgb_q <= sb_pipe_q[LAT].de ? d_in : '0;
    end
  end

  assign row_addr    = row_q;
  assign col_addr    = col_q;
  assign rdn         = rdn_q;
  assign r           = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign g           = rgb_q[2*COLOR_W-1:COLOR_W];
  assign b           = rgb_q[COLOR_W-1:0];
  assign hs          = out_q.hs;
  assign vs          = out_q.vs;
  assign de          = out_q.de;
  assign frame_start = out_q.fs;
  assign line_start  = out_q.ls;
  assign vblank      = out_q.vb;
endmodule
